seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed N-digit seven-segment driver, next generation of the team's single-digit hex decoder.
//  Latches a packed hex word plus per-digit point/enable masks on a load strobe.
//  Scans one digit at a time with a programmable refresh period and an anti-ghosting blank gap.
//  Sits between the datapath debug outputs and the board's shared-segment, per-digit-anode display pins.
// PARAMETERS
//  DIGITS     8      number of digits scanned (1..16)
//  SCAN_DIV   50000  clk cycles each digit is selected (>= 2)
//  BLANK_CYC  16     cycles at the start of each slot with all anodes off (0 <= BLANK_CYC < SCAN_DIV)
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  load       in   1          capture hex_in/point_in/digit_en into shadow registers this cycle
//  hex_in     in   4*DIGITS   digit i = hex_in[4i+3:4i]; digit 0 is rightmost
//  point_in   in   DIGITS     decimal point request per digit, 1 = lit
//  digit_en   in   DIGITS     1 = digit shown, 0 = digit blanked (segments and dp off)
//  seg_n      out  7          active-low segments {a,b,c,d,e,f,g}; MSB = a
//  dp_n       out  1          active-low decimal point
//  an_n       out  DIGITS     active-low anode select, one-hot-low or all-high
//  frame_tick out  1          1-cycle pulse when digit index wraps DIGITS-1 -> 0
// BEHAVIOUR
//  Reset: div_cnt=0, idx=0, shadow hex/point/enable=0, seg_n=7'h7F, dp_n=1, an_n=all 1, frame_tick=0.
//  div_cnt counts 0..SCAN_DIV-1, then returns to 0. At the terminal count idx advances; DIGITS-1 wraps to 0 with frame_tick=1 that cycle.
//  All outputs are registered; each reflects the idx/div_cnt values from the previous cycle (1-cycle latency).
//  While div_cnt < BLANK_CYC: an_n = all 1 and seg_n = 7'h7F.
//  Otherwise: an_n[idx] = ~sh_en[idx], with all other anodes 1.
//    seg_n = decode(sh_hex[idx]) when sh_en[idx], else 7'h7F.
//    dp_n = ~(sh_pt[idx] & sh_en[idx]).
//  Decode table (a..g, active low): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111
//                                   8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000
//  load: the shadow registers update on that edge, mid-slot included. The new value appears on the outputs on the next edge; no frame sync.
//  load held high: the shadow registers track the inputs every cycle.
//  DIGITS=1: idx stays 0, and frame_tick pulses every SCAN_DIV cycles.
//  Async rst mid-scan: all state and outputs go to their reset values immediately. Scanning restarts at digit 0 with a full blank gap.
// CONFIGURATION
//  SEG7_ZERO_BLANK_EN defined: a digit is suppressed as if digit_en=0 when three conditions all hold:
//    it is a leading zero, i.e. its sh_hex is 0 and every higher-indexed enabled digit is also 0;
//    it is not digit 0;
//    its point is off.
//    Suppression is evaluated from the shadow regs, combinationally per idx, before the output register.
//  SEG7_ZERO_BLANK_EN undefined: every enabled digit is displayed, including leading zeros.
// STRUCTURE
//  Package seg7_pkg: SEG_BLANK = 7'h7F constant; 16-entry SEG_HEX lookup table; seg_t typedef (logic [6:0]).
//  Sub-module seg7_hex_decode: combinational 4-bit -> seg_t via SEG_HEX. It is instantiated once, on the muxed digit.
//  Counter width is $clog2(SCAN_DIV); idx width is $clog2(DIGITS) with a minimum of 1.
// TESTING  (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2 unless noted)
//  1 Reset: assert rst mid-slot -> same cycle an_n=4'hF, seg_n=7'h7F, dp_n=1; after release, first anode low (an_n=4'b1110) at cycle 3.
//  2 Scan: load hex_in=16'h3A71, en=4'hF -> slot0 seg_n=1001111 (1), slot1 0001111 (7), slot2 0001000 (A), slot3 0000110 (3); frame_tick every 32 cycles.
//  3 Blank gap: in each slot an_n=4'hF for exactly 2 cycles, then one anode low for 6 cycles; never two anodes low at once.
//  4 Masks: en=4'b1011, point_in=4'b0110 -> slot2 an_n=4'hF and seg_n=7'h7F; slot1 dp_n=0; slot0 dp_n=1.
//  5 Mid-slot load: change hex_in from 8 to F during slot0 with load=1 for 1 cycle -> seg_n changes 0000000 -> 0111000 one cycle later; idx unaffected.
//  6 SEG7_ZERO_BLANK_EN: hex_in=16'h0050, en=4'hF -> digits 3 and 2 blank, digits 1 and 0 shown ('5','0');
//    repeat with point_in[3]=1 -> digit 3 shows '0.'.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// SEG_HEX is indexed by the nibble value. Each entry is {a,b,c,d,e,f,g},
// active low, MSB = a.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_HEX [0:15] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low seven-segment pattern decoder.
// Latency: combinational, zero cycles.
// Backpressure: none; the output follows the input continuously.
//
// Ports: hex (4-bit digit value in), seg (seg_t pattern out, {a..g}, active low).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  assign seg = SEG_HEX[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver with blank gap.
// Latency: all outputs registered, one cycle behind scan state and shadow regs.
// Backpressure: none; load is sampled every cycle, the scan free-runs.
//
// Ports:
//   clk, rst               clock (rising edge), async active-high reset
//   load                   capture hex_in/point_in/digit_en into the shadow regs
//   hex_in[4*DIGITS]       digit i = hex_in[4i+3:4i], digit 0 rightmost
//   point_in, digit_en     per-digit decimal point request / digit enable
//   seg_n, dp_n            active-low segments {a..g} and decimal point
//   an_n                   active-low anode select, one low or all high
//   frame_tick             one-cycle pulse when the digit index wraps to 0
// Optional build macro: SEG7_ZERO_BLANK_EN suppresses leading zeros.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   hex_in,
  input  logic [DIGITS-1:0]     point_in,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  // Scan state
  logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  // Shadow registers
  logic [4*DIGITS-1:0] sh_hex_q, sh_hex_d;
  logic [DIGITS-1:0]   sh_pt_q, sh_pt_d;
  logic [DIGITS-1:0]   sh_en_q, sh_en_d;

  // Output registers
  seg_t                seg_n_q, seg_n_d;
  logic                dp_n_q, dp_n_d;
  logic [DIGITS-1:0]   an_n_q, an_n_d;
  logic                frame_tick_q, frame_tick_d;

  // Currently selected digit
  logic [3:0]          sel_hex;
  logic                sel_pt;
  logic                sel_en;
  logic                suppress;
  logic                show;
  logic                in_blank;
  seg_t                dec_seg;

  // ---------------------------------------------------------------------------
  // Scan counter and digit index
  // ---------------------------------------------------------------------------
  always_comb begin
    div_cnt_d    = div_cnt_q + 1'b1;
    idx_d        = idx_q;
    frame_tick_d = 1'b0;
    if (div_cnt_q == CNT_LAST) begin
      div_cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d        = '0;
        frame_tick_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow registers: no frame alignment, a load lands mid-slot if it must.
  // ---------------------------------------------------------------------------
  always_comb begin
    sh_hex_d = sh_hex_q;
    sh_pt_d  = sh_pt_q;
    sh_en_d  = sh_en_q;
    if (load) begin
      sh_hex_d = hex_in;
      sh_pt_d  = point_in;
      sh_en_d  = digit_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit mux; a single decoder serves every digit.
  // ---------------------------------------------------------------------------
  assign sel_hex = sh_hex_q[{idx_q, 2'b00} +: 4];
  assign sel_pt  = sh_pt_q[idx_q];
  assign sel_en  = sh_en_q[idx_q];

  seg7_hex_decode u_hex_decode (
    .hex (sel_hex),
    .seg (dec_seg)
  );

`ifdef SEG7_ZERO_BLANK_EN
  // A zero is "leading" only if no enabled higher digit holds a non-zero
  // value; disabled digits do not count. Digit 0 and digits with a lit
  // point always show so the display never goes fully dark on a value of 0.
  logic higher_nz;

  always_comb begin
    higher_nz = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if ((j > int'(idx_q)) && sh_en_q[j] && (sh_hex_q[4*j +: 4] != 4'h0)) begin
        higher_nz = 1'b1;
      end
    end
    suppress = (sel_hex == 4'h0) && !higher_nz && (idx_q != '0) && !sel_pt;
  end
`else
  assign suppress = 1'b0;
`endif

  assign show     = sel_en & ~suppress;
  assign in_blank = (div_cnt_q < BLANK_LIM);

  // ---------------------------------------------------------------------------
  // Output decode. During the blank gap everything is dark, including the
  // point, so no segment lingers while the anodes switch.
  // ---------------------------------------------------------------------------
  always_comb begin
    an_n_d  = '1;
    seg_n_d = SEG_BLANK;
    dp_n_d  = 1'b1;
    if (!in_blank) begin
      an_n_d[idx_q] = ~show;
      seg_n_d       = show ? dec_seg : SEG_BLANK;
      dp_n_d        = ~(sel_pt & sel_en);
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      sh_hex_q     <= '0;
      sh_pt_q      <= '0;
      sh_en_q      <= '0;
      seg_n_q      <= SEG_BLANK;
      dp_n_q       <= 1'b1;
      an_n_q       <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      sh_hex_q     <= sh_hex_d;
      sh_pt_q      <= sh_pt_d;
      sh_en_q      <= sh_en_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      an_n_q       <= an_n_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign an_n       = an_n_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2).
// Reference model: position-in-frame arithmetic plus a segment-letter table.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_seg7_scan_driver;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] hex_in;
  logic [3:0]  point_in;
  logic [3:0]  digit_en;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGITS    (DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .hex_in     (hex_in),
    .point_in   (point_in),
    .digit_en   (digit_en),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_tick (frame_tick)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Lit segments per hex digit, by letter.
  string seg_tbl [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                          "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                          "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  int          t;       // clock edges since reset release
  logic [15:0] m_hex;
  logic [3:0]  m_pt, m_en;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_ft;

  function automatic logic [6:0] ref_seg(input logic [3:0] h);
    string      s;
    logic [6:0] r;
    s = seg_tbl[h];
    r = 7'h7F;
    // letter 'a' (ASCII 97) is bit 6
    for (int k = 0; k < s.len(); k++) r[6 - (int'(s[k]) - 97)] = 1'b0;
    return r;
  endfunction

  function automatic bit leading_zero(input int i);
    if (i == 0 || m_pt[i] || m_hex[4*i +: 4] != 4'h0) return 1'b0;
    for (int j = i + 1; j < DIGITS; j++)
      if (m_en[j] && m_hex[4*j +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    t     = 0;
    m_hex = '0;
    m_pt  = '0;
    m_en  = '0;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_ft  = 1'b0;
  endtask

  // Expected outputs after an edge that saw scan position pos.
  task automatic model_eval(input int pos);
    int div, idx;
    bit show;
    div   = pos % SCAN_DIV;
    idx   = (pos / SCAN_DIV) % DIGITS;
    e_ft  = (div == SCAN_DIV - 1) && (idx == DIGITS - 1);
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (div >= BLANK_CYC) begin
`ifdef SEG7_ZERO_BLANK_EN
      show = m_en[idx] && !leading_zero(idx);
`else
      show = m_en[idx];
`endif
      if (show) begin
        e_an  = ~(4'b0001 << idx);
        e_seg = ref_seg(m_hex[4*idx +: 4]);
      end
      e_dp = !(m_pt[idx] && m_en[idx]);
    end
  endtask

  task automatic check_outputs();
    chk("an_n", an_n, e_an);
    chk("seg_n", seg_n, e_seg);
    chk("dp_n", dp_n, e_dp);
    chk("frame_tick", frame_tick, e_ft);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) begin
      t++;
      model_eval(t - 1);
      if (load) begin
        m_hex = hex_in;
        m_pt  = point_in;
        m_en  = digit_en;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Step at least once, then until the edge count lands on a frame phase.
  task automatic run_to(input int ph);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((t % FRAME) != ph && n < 2 * FRAME);
    chk("run_to_phase", t % FRAME, ph);
  endtask

  task automatic load_once(input logic [15:0] h, input logic [3:0] pt, input logic [3:0] en);
    hex_in   = h;
    point_in = pt;
    digit_en = en;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int last_ft;
    int n;
    logic [15:0] rh;

    rst = 1'b1; load = 1'b0; hex_in = '0; point_in = '0; digit_en = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Scan of 3A71 and frame period
    load_once(16'h3A71, 4'h0, 4'hF);
    last_ft = -1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (frame_tick) begin
        if (last_ft >= 0) chk("frame_period", t - last_ft, FRAME);
        last_ft = t;
      end
    end
    chk("frame_seen", (last_ft >= 0), 1);
    run_to(5);
    chk("slot0_seg", seg_n, 7'b1001111);
    chk("slot0_an", an_n, 4'b1110);
    run_to(13);
    chk("slot1_seg", seg_n, 7'b0001111);
    run_to(21);
    chk("slot2_seg", seg_n, 7'b0001000);
    chk("slot2_an", an_n, 4'b1011);
    run_to(29);
    chk("slot3_seg", seg_n, 7'b0000110);

    // Masks
    load_once(16'h1234, 4'b0110, 4'b1011);
    run_to(13);
    chk("mask_slot1_dp", dp_n, 1'b0);
    run_to(21);
    chk("mask_slot2_an", an_n, 4'hF);
    chk("mask_slot2_seg", seg_n, 7'h7F);
    run_to(5);
    chk("mask_slot0_dp", dp_n, 1'b1);

    // Mid-slot load
    load_once(16'h8888, 4'h0, 4'hF);
    run_to(3);
    hex_in = 16'hFFFF;
    load   = 1'b1;
    step();
    load   = 1'b0;
    chk("midload_old_seg", seg_n, 7'b0000000);
    step();
    chk("midload_new_seg", seg_n, 7'b0111000);
    chk("midload_an", an_n, 4'b1110);

    // Leading zeros
    load_once(16'h0050, 4'h0, 4'hF);
    run_to(29);
`ifdef SEG7_ZERO_BLANK_EN
    chk("zb_digit3_an", an_n, 4'hF);
`else
    chk("zb_digit3_an", an_n, 4'b0111);
    chk("zb_digit3_seg", seg_n, 7'b0000001);
`endif
    run_to(13);
    chk("zb_digit1_seg", seg_n, 7'b0100100);
    load_once(16'h0050, 4'b1000, 4'hF);
    run_to(29);
    chk("zb_point_an", an_n, 4'b0111);
    chk("zb_point_seg", seg_n, 7'b0000001);
    chk("zb_point_dp", dp_n, 1'b0);

    // Async reset mid-slot
    run_to(12);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    hex_in = 16'h3A71; point_in = 4'h0; digit_en = 4'hF;
    load = 1'b1;
    rst  = 1'b0;
    n = 0;
    do begin
      step();
      load = 1'b0;
      n++;
    end while (an_n == 4'hF && n < 10);
    chk("first_anode_cycle", n, 3);
    chk("first_anode", an_n, 4'b1110);

    // Random traffic, zero-heavy so leading-zero rules get exercised
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        n = $urandom_range(1, 3);
        for (int b = 0; b < n; b++) begin
          for (int d = 0; d < DIGITS; d++)
            rh[4*d +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
          hex_in   = rh;
          point_in = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
          digit_en = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
          load     = 1'b1;
          step();
        end
        load = 1'b0;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
